// File: rtl/rank_filter_pkg.sv
// rtl/rank_filter_pkg.sv - shared constants and helpers for the rank-order filter
package rank_filter_pkg;

    localparam int RANK_MIN  = 0;
    localparam int PIX_W_MAX = 16;

    // Widest pixel the filter supports; narrower pixels live in its low bits.
    typedef logic [PIX_W_MAX-1:0] pix_t;

    function automatic int rank_median(input int n);
        return (n - 1) / 2;
    endfunction

    // Odd layers pair (0,1),(2,3)...; even layers pair (1,2),(3,4)...
    function automatic int cx_pairs_start(input int stage);
        return (stage % 2 == 1) ? 0 : 1;
    endfunction

endpackage

// File: rtl/cmp_exchange.sv
// rtl/cmp_exchange.sv - stable unsigned compare-exchange cell
module cmp_exchange #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    logic swap;

    // Swap only on strict inequality so equal keys keep their order.
    assign swap = (b < a);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/rank_filter_pipe.sv
// rtl/rank_filter_pipe.sv - pipelined odd-even transposition rank-order filter
module rank_filter_pipe
    import rank_filter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_TAPS = 9,
    parameter int RANK_W = $clog2(N_TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_TAPS*DATA_W-1:0] in_window,
    input  logic [RANK_W-1:0]        in_rank,
    input  logic                     in_sof,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_pixel,
    output logic                     out_sof
);

    localparam logic [RANK_W-1:0] RANK_MAX = RANK_W'(N_TAPS - 1);

    logic                advance;
    logic [RANK_W-1:0]   rank_clamped;
    logic [DATA_W-1:0]   stg_win [0:N_TAPS][N_TAPS];
    logic [DATA_W-1:0]   lyr_out [1:N_TAPS][N_TAPS];
    logic [RANK_W-1:0]   stg_rank [0:N_TAPS];
    logic [N_TAPS:0]     stg_sof;
    logic [N_TAPS:0]     stg_vld;

    // One global enable: the whole pipe moves whenever the output slot frees up.
    assign advance      = out_ready | ~out_valid;
    assign in_ready     = advance;
    assign rank_clamped = (in_rank > RANK_MAX) ? RANK_MAX : in_rank;

    for (genvar s = 1; s <= N_TAPS; s++) begin : g_layer
        localparam int START = cx_pairs_start(s);

        for (genvar p = 0; p < N_TAPS / 2; p++) begin : g_pair
            cmp_exchange #(.DATA_W(DATA_W)) u_cx (
                .a  (stg_win[s-1][START + 2*p]),
                .b  (stg_win[s-1][START + 2*p + 1]),
                .lo (lyr_out[s][START + 2*p]),
                .hi (lyr_out[s][START + 2*p + 1])
            );
        end

        // With an odd window exactly one tap is unpaired in every layer.
        if (START == 0) begin : g_pass_hi
            assign lyr_out[s][N_TAPS-1] = stg_win[s-1][N_TAPS-1];
        end else begin : g_pass_lo
            assign lyr_out[s][0] = stg_win[s-1][0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= N_TAPS; s++) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    stg_win[s][k] <= '0;
                end
                stg_rank[s] <= '0;
            end
            stg_sof   <= '0;
            stg_vld   <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_sof   <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < N_TAPS; k++) begin
                stg_win[0][k] <= in_window[k*DATA_W +: DATA_W];
            end
            stg_rank[0] <= rank_clamped;
            stg_sof[0]  <= in_sof;
            stg_vld[0]  <= in_valid;
            for (int s = 1; s <= N_TAPS; s++) begin
                stg_win[s]  <= lyr_out[s];
                stg_rank[s] <= stg_rank[s-1];
                stg_sof[s]  <= stg_sof[s-1];
                stg_vld[s]  <= stg_vld[s-1];
            end
            out_valid <= stg_vld[N_TAPS];
            out_pixel <= stg_win[N_TAPS][stg_rank[N_TAPS]];
            // Bubbles never present a tag downstream.
            out_sof   <= stg_sof[N_TAPS] & stg_vld[N_TAPS];
        end
    end

endmodule

// File: tb/tb_rank_filter_pipe.sv
// tb/tb_rank_filter_pipe.sv - directed and streaming checks for rank_filter_pipe
module tb_rank_filter_pipe;
    import rank_filter_pkg::*;

    localparam int DATA_W = 8;
    localparam int N_TAPS = 9;
    localparam int RANK_W = 4;
    localparam int LAT    = 11;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [N_TAPS*DATA_W-1:0] in_window = '0;
    logic [RANK_W-1:0]        in_rank = '0;
    logic                     in_sof = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [DATA_W-1:0]        out_pixel;
    logic                     out_sof;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [N_TAPS*DATA_W-1:0] win;
        logic [RANK_W-1:0]        rank;
        logic [DATA_W-1:0]        exp;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] pix;
        logic              sof;
        int                cyc;
    } exp_t;

    vec_t vecs[$];

    rank_filter_pipe #(.DATA_W(DATA_W), .N_TAPS(N_TAPS), .RANK_W(RANK_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_window (in_window),
        .in_rank   (in_rank),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_sof   (out_sof)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [N_TAPS*DATA_W-1:0] pack9(input int t0, input int t1, input int t2,
                                                       input int t3, input int t4, input int t5,
                                                       input int t6, input int t7, input int t8);
        return {8'(t8), 8'(t7), 8'(t6), 8'(t5), 8'(t4), 8'(t3), 8'(t2), 8'(t1), 8'(t0)};
    endfunction

    // Reference: plain bubble sort of the taps, then pick the clamped rank.
    function automatic logic [DATA_W-1:0] ref_rank(input logic [N_TAPS*DATA_W-1:0] w,
                                                   input logic [RANK_W-1:0] r);
        int a [N_TAPS];
        int t;
        int ri;
        for (int k = 0; k < N_TAPS; k++) a[k] = int'(w[k*DATA_W +: DATA_W]);
        for (int i = 0; i < N_TAPS; i++)
            for (int j = 0; j < N_TAPS - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        ri = (int'(r) > N_TAPS - 1) ? N_TAPS - 1 : int'(r);
        return DATA_W'(a[ri]);
    endfunction

    function automatic logic [N_TAPS*DATA_W-1:0] rand_win(input bit narrow);
        logic [N_TAPS*DATA_W-1:0] w;
        for (int k = 0; k < N_TAPS; k++)
            w[k*DATA_W +: DATA_W] = narrow ? DATA_W'($urandom_range(0, 7)) : DATA_W'($urandom_range(0, 255));
        return w;
    endfunction

    // Single beat into an otherwise idle pipe; measures latency in clock edges.
    task automatic send_one(input string nm, input logic [N_TAPS*DATA_W-1:0] w,
                            input logic [RANK_W-1:0] r, input logic [DATA_W-1:0] exp);
        int n;
        @(negedge clk);
        out_ready = 1'b1;
        in_window = w;
        in_rank   = r;
        in_sof    = 1'b0;
        in_valid  = 1'b1;
        #1;
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({nm, "_latency"}, 32'(n), 32'(LAT));
        check({nm, "_pixel"}, 32'(out_pixel), 32'(exp));
    endtask

    task automatic run_stream(input string nm, input int nbeats, input bit bp, input int tag_idx);
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic [4:0] pat = 5'b01001;
        logic [N_TAPS*DATA_W-1:0] cw;
        logic [RANK_W-1:0] cr;
        logic stalled = 1'b0;
        logic [DATA_W-1:0] hold_pix = '0;
        logic hold_sof = 1'b0;
        logic exp_rdy;
        cw = rand_win(1'b0);
        cr = RANK_W'($urandom_range(0, 15));
        while ((sent < nbeats || got < nbeats) && cyc < 3000) begin
            @(negedge clk);
            out_ready = bp ? pat[cyc % 5] : 1'b1;
            in_valid  = (sent < nbeats);
            in_window = cw;
            in_rank   = cr;
            in_sof    = (sent == tag_idx);
            #1;
            if (stalled) begin
                check({nm, "_stall_valid"}, 32'(out_valid), 32'd1);
                check({nm, "_stall_pixel"}, 32'(out_pixel), 32'(hold_pix));
                check({nm, "_stall_sof"}, 32'(out_sof), 32'(hold_sof));
            end
            exp_rdy = !(out_valid && !out_ready);
            check({nm, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check({nm, "_extra_result"}, 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check({nm, "_pixel"}, 32'(out_pixel), 32'(e.pix));
                    check({nm, "_sof"}, 32'(out_sof), 32'(e.sof));
                    if (!bp) check({nm, "_latency"}, 32'(cyc - e.cyc), 32'(LAT));
                end
                got++;
            end
            stalled  = out_valid && !out_ready;
            hold_pix = out_pixel;
            hold_sof = out_sof;
            if (in_valid && in_ready) begin
                e.pix = ref_rank(cw, cr);
                e.sof = (sent == tag_idx);
                e.cyc = cyc;
                q.push_back(e);
                sent++;
                cw = rand_win(sent % 3 == 0);
                cr = RANK_W'($urandom_range(0, 15));
            end
            cyc++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check({nm, "_count"}, 32'(got), 32'(nbeats));
        check({nm, "_drain"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [N_TAPS*DATA_W-1:0] w_mix;
        logic [N_TAPS*DATA_W-1:0] w_dup;
        logic [N_TAPS*DATA_W-1:0] w_eq;
        int stale;

        w_mix = pack9(9, 1, 8, 2, 7, 3, 6, 4, 5);
        w_dup = pack9(255, 0, 255, 0, 255, 0, 255, 0, 128);
        w_eq  = pack9(37, 37, 37, 37, 37, 37, 37, 37, 37);

        vecs.push_back('{w_mix, RANK_W'(rank_median(N_TAPS)), 8'd5});
        vecs.push_back('{w_mix, RANK_W'(RANK_MIN), 8'd1});
        vecs.push_back('{w_mix, 4'd8, 8'd9});
        vecs.push_back('{w_mix, 4'd15, 8'd9});
        vecs.push_back('{w_mix, 4'd2, 8'd3});
        vecs.push_back('{w_mix, 4'd6, 8'd7});
        vecs.push_back('{w_dup, 4'd4, 8'd128});
        vecs.push_back('{w_dup, 4'd3, 8'd0});
        vecs.push_back('{w_dup, 4'd5, 8'd255});
        vecs.push_back('{w_dup, 4'd9, 8'd255});
        for (int r = 0; r < N_TAPS; r++) vecs.push_back('{w_eq, RANK_W'(r), 8'd37});

        // Reset held with a beat on the input: nothing may come out.
        in_valid  = 1'b1;
        in_window = w_mix;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_out_valid", 32'(out_valid), 32'd0);
            check("reset_out_pixel", 32'(out_pixel), 32'd0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            send_one($sformatf("vec%0d", i), vecs[i].win, vecs[i].rank, vecs[i].exp);

        run_stream("stream", 100, 1'b0, 37);
        run_stream("bp", 40, 1'b1, 11);

        // Fill the pipe until results flow, then reset with beats in flight.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_rank   = 4'd4;
            in_window = rand_win(1'b0);
        end
        @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_pixel", 32'(out_pixel), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_after_reset", 32'(stale), 32'd0);
        send_one("post_reset", w_mix, 4'd4, 8'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
